dpram_be: RTL
=============

DPRAM_BE -- requirements
Module: dpram_be

Interface
REQ-001 Parameter DW, default 16, data width in bits; SHALL be a multiple of 8, minimum 8.
REQ-002 Parameter AW, default 14, address width; depth SHALL be 2^AW words.
REQ-003 Parameter CLEAR_ON_RESET, default 1, 1 = zero-fill memory after reset release.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset_n  input  1  reset is asynchronous and active-low.
REQ-006 clr  input  1  one-cycle request to start a zero-fill from IDLE.
REQ-007 ada, adb  input  AW  port A / port B word address.
REQ-008 dina, dinb  input  DW  port A / port B write data.
REQ-009 bea, beb  input  DW/8  per-byte write enables; bit i covers data bits 8i+7..8i.
REQ-010 cea, ceb  input  1  port access enable.
REQ-011 wrea, wreb  input  1  write qualifier; read-only access when 0.
REQ-012 ocea, oceb  input  1  output register enable.
REQ-013 douta, doutb  output  DW  registered read data.
REQ-014 busy  output  1  high while zero-fill in progress; port accesses ignored.

Function
REQ-015 Effective write of port X per byte i SHALL be ceX & wreX & beX[i] & !busy.
REQ-016 Writes with all byte enables 0 SHALL leave memory unchanged but still perform a read.
REQ-017 Same-address same-cycle writes SHALL resolve per byte: byte enabled on A stored from dina; byte enabled only on B stored from dinb.
REQ-018 Different-address writes on both ports in one cycle SHALL both complete.
REQ-019 Stage-1 read register of port X SHALL load when ceX & !busy, else hold.
REQ-020 Stage-1 value SHALL be write-first: per byte, the value memory holds after that edge's writes (own write, other port's write to same address, or old content), using REQ-017 priority.
REQ-021 doutX SHALL load stage-1 value of port X when oceX=1, else hold; read latency 2 edges with oceX held 1.
REQ-022 Clear FSM states: IDLE, CLEAR; counter clr_ad of width AW.
REQ-023 IDLE -> CLEAR on clr=1; clr_ad set to 0; busy=1 from next cycle.
REQ-024 CLEAR: each edge write zero to all bytes of mem[clr_ad], increment clr_ad; at clr_ad = 2^AW-1 write then -> IDLE; busy=0 next cycle.
REQ-025 Zero-fill SHALL take exactly 2^AW edges; clr ignored while in CLEAR.
REQ-026 While busy, stage-1 and dout registers SHALL hold; inputs other than reset_n ignored.
REQ-027 With CLEAR_ON_RESET=0 initial memory content is unspecified and FSM leaves reset in IDLE.

Reset
REQ-028 reset_n low SHALL immediately set douta, doutb, stage-1 registers, clr_ad to 0.
REQ-029 reset_n low SHALL set FSM to CLEAR with busy=1 if CLEAR_ON_RESET=1, else IDLE with busy=0.
REQ-030 Reset SHALL not itself modify memory; zero-fill starts at first edge with reset_n high.
REQ-031 Reset asserted mid-CLEAR SHALL restart zero-fill from address 0.

Verification (bench AW=4, DW=16)
REQ-032 Release reset, CLEAR_ON_RESET=1 -> busy=1 for 16 edges then 0; read all addresses -> 0x0000.
REQ-033 A writes 0x1234 be=11 to addr 3, then A reads 3 with ocea=1 -> douta=0x1234 two edges after read issue.
REQ-034 Same edge: A write addr 5 be=01 0x00AA, B write addr 5 be=11 0xBBCC -> mem[5]=0xBBAA; douta and doutb both 0xBBAA after latency.
REQ-035 Same edge: A write addr 7 be=11 0x1111, B write addr 7 be=11 0x2222 -> mem[7]=0x1111; doutb=0x1111.
REQ-036 ocea=0 while reading new data -> douta holds previous value; raise ocea -> updates on next edge.
REQ-037 Pulse clr after writes, assert reset_n low at clr_ad=8 -> outputs 0 at once; after release 16-edge fill restarts; all words 0.

Source files
------------

// File: rtl/dpram_be_if.sv
// Port bundle for the byte-enabled dual-port RAM: two access ports plus zero-fill control.
// The master side drives addresses, data and strobes; the slave side returns data and busy.
interface dpram_be_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 14
);
  localparam int unsigned BW = DW / 8;

  logic          clr;
  logic          busy;
  logic [AW-1:0] ada;
  logic [AW-1:0] adb;
  logic [DW-1:0] dina;
  logic [DW-1:0] dinb;
  logic [BW-1:0] bea;
  logic [BW-1:0] beb;
  logic          cea;
  logic          ceb;
  logic          wrea;
  logic          wreb;
  logic          ocea;
  logic          oceb;
  logic [DW-1:0] douta;
  logic [DW-1:0] doutb;

  modport master (
    output clr, ada, adb, dina, dinb, bea, beb, cea, ceb, wrea, wreb, ocea, oceb,
    input  douta, doutb, busy
  );

  modport slave (
    input  clr, ada, adb, dina, dinb, bea, beb, cea, ceb, wrea, wreb, ocea, oceb,
    output douta, doutb, busy
  );
endinterface

// File: rtl/dpram_be.sv
// True dual-port RAM with per-byte write enables, write-first read path, two-stage
// registered outputs and an optional hardware zero-fill sequencer.
module dpram_be #(
  parameter int unsigned DW             = 16,
  parameter int unsigned AW             = 14,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input logic     clk,
  input logic     reset_n,
  dpram_be_if.slave bus
);
  localparam int unsigned NB    = DW / 8;
  localparam int unsigned Depth = 2 ** AW;

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e        state_q;
  logic          busy_q;
  logic [AW-1:0] clr_ad_q;

  logic [DW-1:0] mem [Depth];

  logic [NB-1:0] we_a;
  logic [NB-1:0] we_b;
  logic [NB-1:0] we_b_mem;
  logic          same_ad;
  logic [DW-1:0] rd_a_d, rd_a_q;
  logic [DW-1:0] rd_b_d, rd_b_q;
  logic [DW-1:0] douta_q, doutb_q;

  // Per-byte effective strobes; port A owns a byte both ports write to the same word.
  always_comb begin
    same_ad  = (bus.ada == bus.adb);
    we_a     = '0;
    we_b     = '0;
    we_b_mem = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      we_a[i]     = bus.cea & bus.wrea & bus.bea[i] & ~busy_q;
      we_b[i]     = bus.ceb & bus.wreb & bus.beb[i] & ~busy_q;
      we_b_mem[i] = we_b[i] & ~(same_ad & we_a[i]);
    end
  end

  // Write-first read data: what each addressed word will hold after this edge.
  always_comb begin
    rd_a_d = mem[bus.ada];
    rd_b_d = mem[bus.adb];
    for (int unsigned i = 0; i < NB; i++) begin
      if (we_a[i]) begin
        rd_a_d[8*i +: 8] = bus.dina[8*i +: 8];
      end else if (we_b[i] && same_ad) begin
        rd_a_d[8*i +: 8] = bus.dinb[8*i +: 8];
      end
      if (we_a[i] && same_ad) begin
        rd_b_d[8*i +: 8] = bus.dina[8*i +: 8];
      end else if (we_b[i]) begin
        rd_b_d[8*i +: 8] = bus.dinb[8*i +: 8];
      end
    end
  end

  // Memory array has no reset; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (busy_q) begin
        mem[clr_ad_q] <= '0;
      end else begin
        for (int unsigned i = 0; i < NB; i++) begin
          if (we_a[i]) mem[bus.ada][8*i +: 8] <= bus.dina[8*i +: 8];
          if (we_b_mem[i]) mem[bus.adb][8*i +: 8] <= bus.dinb[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= CLEAR_ON_RESET ? StClear : StIdle;
      busy_q   <= CLEAR_ON_RESET;
      clr_ad_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.clr) begin
            state_q  <= StClear;
            busy_q   <= 1'b1;
            clr_ad_q <= '0;
          end
        end
        StClear: begin
          clr_ad_q <= clr_ad_q + 1'b1;
          if (&clr_ad_q) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_a_q  <= '0;
      rd_b_q  <= '0;
      douta_q <= '0;
      doutb_q <= '0;
    end else if (!busy_q) begin
      if (bus.cea)  rd_a_q  <= rd_a_d;
      if (bus.ceb)  rd_b_q  <= rd_b_d;
      if (bus.ocea) douta_q <= rd_a_q;
      if (bus.oceb) doutb_q <= rd_b_q;
    end
  end

  assign bus.douta = douta_q;
  assign bus.doutb = doutb_q;
  assign bus.busy  = busy_q;

endmodule
